// File: rtl/hilo_unit_pkg.sv
// -----------------------------------------------------------------------------
// hilo_unit_pkg
//   Shared constants and types for the HI/LO multiply-sequencing stage.
//   - EX-stage op codes understood by hilo_unit (MULT/MULTU/MTHI/MTLO/MFHI/MFLO).
//   - Sequencer state encoding (HILO_IDLE / HILO_BUSY / HILO_DONE, 2 bits).
//   - HI/LO write-port select type used between the sequencer and hilo_regs.
// -----------------------------------------------------------------------------
package hilo_unit_pkg;

  localparam int DATA_W = 32;
  localparam int PROD_W = 2 * DATA_W;
  localparam int OP_W   = 8;

  // EX-stage ALU op codes (same values as the pipeline's shared op table)
  localparam logic [OP_W-1:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [OP_W-1:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [OP_W-1:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [OP_W-1:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [OP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [OP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;

  typedef enum logic [1:0] {
    HILO_IDLE = 2'b00,
    HILO_BUSY = 2'b01,
    HILO_DONE = 2'b10
  } hilo_state_t;

  typedef enum logic [1:0] {
    HILO_WR_NONE = 2'b00,
    HILO_WR_HI   = 2'b01,
    HILO_WR_LO   = 2'b10,
    HILO_WR_BOTH = 2'b11
  } hilo_wr_t;

  function automatic logic is_mult_op(input logic [OP_W-1:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
  endfunction

endpackage

// File: rtl/hilo_unit_regs.sv
// -----------------------------------------------------------------------------
// hilo_regs
//   HI/LO architectural registers with a single write port and the MFHI/MFLO
//   read mux.
//   Ports:
//     clk, resetn         clock, asynchronous active-low reset (HI=LO=0)
//     wr_sel              which of HI/LO to write this edge (none/hi/lo/both)
//     wr_hi, wr_lo        write data for HI and LO
//     rd_op               EX op code; selects HI (MFHI) or LO (MFLO), else 0
//     hi_o, lo_o          current register contents
//     mf_data             read data for MFHI/MFLO
// -----------------------------------------------------------------------------
module hilo_regs
  import hilo_unit_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  hilo_wr_t          wr_sel,
  input  logic [DATA_W-1:0] wr_hi,
  input  logic [DATA_W-1:0] wr_lo,
  input  logic [OP_W-1:0]   rd_op,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] mf_data
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if ((wr_sel == HILO_WR_HI) || (wr_sel == HILO_WR_BOTH)) hi_q <= wr_hi;
      if ((wr_sel == HILO_WR_LO) || (wr_sel == HILO_WR_BOTH)) lo_q <= wr_lo;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

  // Writers only ever update at a clock edge, so reading the registers
  // directly is always current for the instruction in EX.
  always_comb begin
    mf_data = '0;
    case (rd_op)
      EXE_MFHI_OP: mf_data = hi_q;
      EXE_MFLO_OP: mf_data = lo_q;
      default:     mf_data = '0;
    endcase
  end

endmodule

// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
//   Multiply sequencer and HI/LO stage behind the pipelined MU multiplier.
//   MULT/MULTU in EX latch their operands, pulse mu_start for one cycle and
//   stall IF..EX until MU reports a valid product, which is then committed to
//   HI/LO. MTHI/MTLO write HI/LO directly; MFHI/MFLO read them via mf_data.
//   A flush while waiting aborts the multiply; a watchdog aborts after
//   TIMEOUT busy cycles without a result and pulses mu_timeout.
//   Ports:
//     clk, resetn                  clock, asynchronous active-low reset
//     ex_valid, ex_op, ex_a, ex_b  instruction in EX (rs/rt operands)
//     flush                        kill the EX instruction this cycle
//     mu_start                     one-cycle restart pulse to MU sclr
//     mu_a, mu_b, mu_op            latched operands/op driven to MU
//     mu_result_ok, mu_p           MU product valid / 64-bit product
//     stall_req                    freeze IF..EX (combinational)
//     mf_data                      HI or LO for MFHI/MFLO, otherwise 0
//     hi_o, lo_o                   current HI/LO
//     mu_timeout                   one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_valid,
  input  logic [OP_W-1:0]   ex_op,
  input  logic [DATA_W-1:0] ex_a,
  input  logic [DATA_W-1:0] ex_b,
  input  logic              flush,
  output logic              mu_start,
  output logic [DATA_W-1:0] mu_a,
  output logic [DATA_W-1:0] mu_b,
  output logic [OP_W-1:0]   mu_op,
  input  logic              mu_result_ok,
  input  logic [PROD_W-1:0] mu_p,
  output logic              stall_req,
  output logic [DATA_W-1:0] mf_data,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              mu_timeout
);

  // The busy counter is 4 bits wide; it starts at 0 in the first BUSY cycle,
  // so TIMEOUT busy cycles have elapsed when it reads TIMEOUT-1.
  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  hilo_state_t       state;
  hilo_state_t       state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;

  logic              ex_live;
  logic              go;
  logic              in_busy;
  logic              res_hit;
  logic              wd_abort;

  hilo_wr_t          wr_sel;
  logic [DATA_W-1:0] wr_hi;
  logic [DATA_W-1:0] wr_lo;

  assign ex_live = ex_valid & ~flush;
  assign in_busy = (state == HILO_BUSY);
  assign go      = ex_live & is_mult_op(ex_op) & (state == HILO_IDLE);

  // While mu_start is high MU is being restarted, so any result_ok it shows
  // belongs to an earlier operation. Flush outranks a same-cycle result.
  assign res_hit  = in_busy & ~flush & ~mu_start & mu_result_ok;
  assign wd_abort = in_busy & ~flush & ~res_hit & (cnt == CNT_LAST);

  assign stall_req = go | in_busy;

  // Next-state, counter and HI/LO write-port control
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_sel    = HILO_WR_NONE;
    wr_hi     = ex_a;
    wr_lo     = ex_a;
    case (state)
      HILO_IDLE: begin
        if (go) begin
          state_nxt = HILO_BUSY;
          cnt_nxt   = '0;
        end else if (ex_live && (ex_op == EXE_MTHI_OP)) begin
          wr_sel = HILO_WR_HI;
        end else if (ex_live && (ex_op == EXE_MTLO_OP)) begin
          wr_sel = HILO_WR_LO;
        end
      end
      HILO_BUSY: begin
        cnt_nxt = cnt + 4'd1;
        if (flush) begin
          state_nxt = HILO_IDLE;
        end else if (res_hit) begin
          state_nxt = HILO_DONE;
          wr_sel    = HILO_WR_BOTH;
          wr_hi     = mu_p[PROD_W-1:DATA_W];
          wr_lo     = mu_p[DATA_W-1:0];
        end else if (wd_abort) begin
          state_nxt = HILO_IDLE;
        end
      end
      // The committed multiply is still in EX here; the pipeline now moves
      // it on, so return to IDLE without relaunching or undoing the commit.
      HILO_DONE: state_nxt = HILO_IDLE;
      default:   state_nxt = HILO_IDLE;
    endcase
  end

  // ---- Stage boundary: sequencer state, watchdog, MU launch registers ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= HILO_IDLE;
      cnt        <= '0;
      mu_start   <= 1'b0;
      mu_timeout <= 1'b0;
      mu_a       <= '0;
      mu_b       <= '0;
      mu_op      <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      mu_start   <= go;
      mu_timeout <= wd_abort;
      // Operands stay frozen for MU through BUSY; mu_op carries signedness.
      if (go) begin
        mu_a  <= ex_a;
        mu_b  <= ex_b;
        mu_op <= ex_op;
      end
    end
  end

  hilo_regs u_regs (
    .clk     (clk),
    .resetn  (resetn),
    .wr_sel  (wr_sel),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .rd_op   (ex_op),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .mf_data (mf_data)
  );

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Multiply-sequencing and HI/LO register stage sitting directly downstream of the `MU` pipelined multiplier in EX. It sees MULT/MULTU/MTHI/MTLO/MFHI/MFLO in EX. For multiplies it launches `MU` with stable latched operands, stalls the pipeline until `result_ok`, then commits the 64-bit product into HI/LO. It also serves MFHI/MFLO reads and MTHI/MTLO writes, handles flush and watchdog abort.

## Interface
- `TIMEOUT`, default 15: max BUSY cycles waiting for `mu_result_ok` before abort (4-bit counter, 1..15).
- `clk` in 1: system clock, all state updates on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: EX holds a valid instruction.
- `ex_op` in 8: ALU op code (`EXE_MULT_OP`, `EXE_MULTU_OP`, `EXE_MTHI_OP`, `EXE_MTLO_OP`, `EXE_MFHI_OP`, `EXE_MFLO_OP`; others ignored).
- `ex_a`, `ex_b` in 32 each: rs / rt values (MTHI/MTLO use `ex_a`).
- `flush` in 1: exception/flush of EX this cycle.
- `mu_start` out 1: one-cycle restart pulse to MU `sclr`.
- `mu_a`, `mu_b` out 32 each: latched operands to MU.
- `mu_op` out 8: latched op to MU `alucontrol`.
- `mu_result_ok` in 1: MU product valid.
- `mu_p` in 64: MU product.
- `stall_req` out 1: freeze IF..EX.
- `mf_data` out 32: HI or LO for MFHI/MFLO, 0 otherwise.
- `hi_o`, `lo_o` out 32 each: current HI/LO.
- `mu_timeout` out 1: one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, BUSY, DONE. Reset: IDLE, HI=LO=0, `mu_a`/`mu_b`/`mu_op`=0, `mu_start`=0, `mu_timeout`=0, counter=0.
- Define `go` = `ex_valid` & !`flush` & op∈{MULT,MULTU} & IDLE.
- IDLE, `go`:
  - latch `ex_a`/`ex_b`/`ex_op` into `mu_*`.
  - set `mu_start`=1 for the next cycle.
  - counter=0; go to BUSY.
- IDLE, MTHI/MTLO with `ex_valid` & !`flush`: HI (or LO) = `ex_a` at the edge. The new value is visible on `hi_o`/`mf_data` the next cycle.
- BUSY:
  - `mu_start` is high only in the first BUSY cycle.
  - `mu_result_ok` is ignored while `mu_start` is high (stale result).
  - Counter increments each cycle.
  - On the first qualifying `mu_result_ok`: HI=`mu_p[63:32]`, LO=`mu_p[31:0]`; go to DONE.
- BUSY, `flush`: abort to IDLE. No HI/LO write. Takes priority over a same-cycle `mu_result_ok`.
- BUSY, counter reaches TIMEOUT with no result: pulse `mu_timeout`, go to IDLE, HI/LO unchanged.
- DONE: the multiply is still in EX while the pipeline advances.
  - No restart.
  - Unconditionally go to IDLE.
  - `flush` in DONE does not undo the commit.
- `stall_req` = `go` | BUSY. It is combinational, so it is high in the launch cycle, and low in DONE and IDLE.
- `mf_data`: HI for MFHI, LO for MFLO, read from registers (no same-cycle bypass needed, since writers are sequential).
- `mu_op` is held stable through BUSY; MU signedness comes from it.

## Timing
- Cycle 0: `go`, `stall_req`=1.
- Cycle 1: BUSY, `mu_start`=1.
- MU reports `result_ok` 6 cycles after `sclr`, i.e. cycle 7.
- HI/LO are written at the end of cycle 7.
- Cycle 8: DONE, `stall_req`=0, new HI/LO visible.
- Cycle 9: IDLE, next instruction in EX.
- Total stall: 8 cycles (cycles 0–7).
- Back-to-back MULT: the second is in EX in cycle 9 and launches then.
- `resetn` low mid-BUSY: immediate IDLE, all outputs at reset values, MU result discarded.

## Structure
- Op codes come from the shared `defines.vh`.
- Add `EXE_MFHI_OP`, `EXE_MFLO_OP`, `EXE_MTHI_OP`, `EXE_MTLO_OP` there if missing.
- State encodings: `HILO_IDLE`, `HILO_BUSY`, `HILO_DONE` (2-bit) in `defines2.vh`.
- One natural sub-module: `hilo_regs` (HI/LO storage, write port, MF read mux). The FSM, watchdog and operand latch stay in the top.

## Test plan
- MULT `ex_a`=0xFFFFFFFE, `ex_b`=4:
  - `stall_req` high cycles 0–7, `mu_start` only in cycle 1.
  - Cycle 8: HI=0xFFFFFFFF, LO=0xFFFFFFF8.
- MULTU same operands: HI=0x00000003, LO=0xFFFFFFF8.
- MTHI 0x12345678, then MFHI next cycle: `mf_data`=0x12345678, `stall_req` never asserts.
- MULT 2×4 with `flush` in cycle 4:
  - IDLE in cycle 5, HI/LO keep their old values.
  - A later `mu_result_ok` is ignored.
- MU model never asserts `result_ok`: `mu_timeout` pulses once after 15 BUSY cycles, `stall_req` drops, HI/LO unchanged.
- `resetn` low in cycle 3 of a MULT: HI=LO=0, `stall_req`=0, state IDLE. The following MULTU 3×5 gives LO=15, HI=0.
